player_move_requester: RTL and testbench
========================================

# player_move_requester

Initiator side of the movement-check interface. Accepts one direction command at a time from the input/command decoder and holds the authoritative player position on the 8x4 map. For each command it issues a single-cycle check request to the external forbidden-move checker, then commits the checker's returned position. It reports completion and blocked moves ("bump") to the text/display layer.

## Interface
Parameters:
- START_X, 3'd0: player x position after reset
- START_Y, 2'd0: player y position after reset

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- cmd_dir  input  3  direction: UP=0, DOWN=1, RIGHT=2, LEFT=3, NONE=4; codes 5–7 are treated as NONE
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- chk_posx  output  3  current x, to checker
- chk_posy  output  2  current y, to checker
- chk_dir  output  3  latched direction, to checker
- chk_valid  output  1  request strobe to checker
- chk_positionx  input  3  checker result x (combinational from chk_*)
- chk_positiony  input  2  checker result y
- pos_x  output  3  committed player x
- pos_y  output  2  committed player y
- move_done  output  1  one-cycle pulse, command finished
- bump  output  1  valid with move_done: move was refused
- move_count  output  8  successful move count (see Configuration)

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE**
  - cmd_ready=1.
  - When cmd_valid && cmd_ready: latch cmd_dir, mapping 5–7 to NONE, and go to REQ.
- **REQ**
  - chk_posx/chk_posy = pos_x/pos_y; chk_dir = latched direction.
  - Edge guard: the block refuses locally any move that would leave the grid, with no wrap-around. The cases are UP at y=0, DOWN at y=3, LEFT at x=0, RIGHT at x=7.
  - For an edge-guarded move or NONE: chk_valid=0 and the position is unchanged.
  - Otherwise: chk_valid=1. On the clock edge, capture chk_positionx/chk_positiony into pos_x/pos_y.
  - Register bump=1 if the move was edge-guarded, or if the captured position equals the old position for a non-NONE direction. Otherwise bump=0.
  - Always go to RESP.
- **RESP**
  - move_done=1 and bump is valid for exactly this cycle.
  - Return to IDLE.
- In REQ and RESP: cmd_ready=0, and cmd_valid is ignored. The upstream holds its command until the handshake.
- When not in REQ: chk_valid=0 and chk_dir=NONE. chk_posx/chk_posy always track pos_x/pos_y.
- bump is 0 whenever move_done is 0.

## Timing
- Reset values:
  - state=IDLE, pos_x=START_X, pos_y=START_Y
  - cmd_ready=1, chk_valid=0, chk_dir=NONE
  - move_done=0, bump=0, move_count=0
- Latency, with the handshake at edge N:
  - REQ is in cycle N+1.
  - New pos_x/pos_y and move_done are visible in cycle N+2.
  - cmd_ready returns high in cycle N+3.
- Throughput: one command per 3 cycles. Back-to-back commands use the updated position.
- The checker path is combinational, with no extra wait state. chk_valid lasts exactly one cycle per non-guarded move.
- Reset asserted mid-operation: the block immediately returns to the reset values. The in-flight command is discarded with no move_done.

## Configuration
- MOVE_COUNTER_EN defined:
  - move_count increments by 1 in the cycle move_done=1 with bump=0 and the direction not NONE.
  - It saturates at 8'd255.
- MOVE_COUNTER_EN undefined: the port remains but is tied to 8'd0, and no counter logic is synthesized.

## Structure
- Shared package zork_pkg holds:
  - the direction encodings UP/DOWN/RIGHT/LEFT/NONE (3-bit)
  - GRID_W=8, GRID_H=4, and the position widths
  - FSM state encodings
- The forbidden-move checker is an external peer, wired at the top level. It is not instantiated here.
- One natural sub-module: move_counter (saturating 8-bit counter), instantiated only under MOVE_COUNTER_EN.

## Test plan
- Reset with START=(0,0), then RIGHT → chk_valid pulse with chk_dir=2; checker returns (1,0); pos=(1,0) at N+2; move_done=1, bump=0.
- From (2,0), RIGHT → checker forbids (3,0) and returns (2,0); pos stays (2,0); bump=1; move_count unchanged.
- At (0,0), UP → chk_valid stays 0; pos stays (0,0); bump=1. At (7,3), RIGHT → bump=1, no wrap to x=0.
- cmd_dir=6 → treated as NONE: no chk_valid; move_done=1, bump=0, count unchanged. cmd_valid held during REQ/RESP → only one command consumed.
- Assert rst_n low during REQ → state IDLE, pos=START, move_done never pulses for that command.
- MOVE_COUNTER_EN defined: 260 successful moves → move_count=255. With the macro undefined → move_count=0 throughout.

Source files
------------

// File: rtl/zork_pkg.sv
// Shared definitions for the movement-check interface: direction codes,
// map geometry and requester FSM states.
package zork_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_NONE  = 3'd4
  } dir_e;

  localparam int GRID_W = 8;
  localparam int GRID_H = 4;
  localparam int POSX_W = 3;
  localparam int POSY_W = 2;

  localparam logic [POSX_W-1:0] X_MAX = POSX_W'(GRID_W - 1);
  localparam logic [POSY_W-1:0] Y_MAX = POSY_W'(GRID_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Codes 5-7 have no movement meaning and collapse onto NONE.
  function automatic dir_e norm_dir(input logic [2:0] d);
    return (d > 3'd4) ? DIR_NONE : dir_e'(d);
  endfunction

  // True when the move would step off the map (no wrap-around).
  function automatic logic edge_guard(input dir_e d,
                                      input logic [POSX_W-1:0] x,
                                      input logic [POSY_W-1:0] y);
    case (d)
      DIR_UP:    return y == '0;
      DIR_DOWN:  return y == Y_MAX;
      DIR_RIGHT: return x == X_MAX;
      DIR_LEFT:  return x == '0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/player_move_requester_move_counter.sv
// move_counter: saturating 8-bit count of successful moves.
module move_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  output logic [7:0] count_o
);

  logic [7:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= 8'd0;
    else if (inc_i && count_q != 8'hFF)
      count_q <= count_q + 8'd1;
  end

  assign count_o = count_q;

endmodule

// File: rtl/player_move_requester.sv
// Player move requester: owns the player position and asks the external
// forbidden-move checker about each command. MOVE_COUNTER_EN adds a move counter.
module player_move_requester
  import zork_pkg::*;
#(
  parameter logic [2:0] START_X = 3'd0,
  parameter logic [1:0] START_Y = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] cmd_dir,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [2:0] chk_posx,
  output logic [1:0] chk_posy,
  output logic [2:0] chk_dir,
  output logic       chk_valid,
  input  logic [2:0] chk_positionx,
  input  logic [1:0] chk_positiony,
  output logic [2:0] pos_x,
  output logic [1:0] pos_y,
  output logic       move_done,
  output logic       bump,
  output logic [7:0] move_count
);

  state_e      state_q;
  dir_e        dir_q;
  dir_e        chk_dir_q;
  logic        chk_valid_q;
  logic        cmd_ready_q;
  logic        done_q;
  logic        bump_q;
  logic [2:0]  pos_x_q;
  logic [1:0]  pos_y_q;

  dir_e        cmd_norm;
  logic        cmd_guard;
  logic        req_guard;
  logic        req_stay;

  assign cmd_norm  = norm_dir(cmd_dir);
  assign cmd_guard = edge_guard(cmd_norm, pos_x_q, pos_y_q);
  assign req_guard = edge_guard(dir_q, pos_x_q, pos_y_q);
  assign req_stay  = (chk_positionx == pos_x_q) && (chk_positiony == pos_y_q);

  // Request strobe and direction are decided at the handshake so that they
  // come straight from flops during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dir_q       <= DIR_NONE;
      chk_dir_q   <= DIR_NONE;
      chk_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      bump_q      <= 1'b0;
      pos_x_q     <= START_X;
      pos_y_q     <= START_Y;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            dir_q       <= cmd_norm;
            chk_dir_q   <= cmd_norm;
            chk_valid_q <= (cmd_norm != DIR_NONE) && !cmd_guard;
            cmd_ready_q <= 1'b0;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          chk_valid_q <= 1'b0;
          chk_dir_q   <= DIR_NONE;
          if (chk_valid_q) begin
            pos_x_q <= chk_positionx;
            pos_y_q <= chk_positiony;
          end
          bump_q  <= (dir_q != DIR_NONE) && (req_guard || req_stay);
          done_q  <= 1'b1;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          done_q      <= 1'b0;
          bump_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          chk_valid_q <= 1'b0;
          chk_dir_q   <= DIR_NONE;
          done_q      <= 1'b0;
          bump_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign chk_posx  = pos_x_q;
  assign chk_posy  = pos_y_q;
  assign chk_dir   = chk_dir_q;
  assign chk_valid = chk_valid_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign move_done = done_q;
  assign bump      = bump_q;

`ifdef MOVE_COUNTER_EN
  move_counter u_move_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (done_q && !bump_q && dir_q != DIR_NONE),
    .count_o(move_count)
  );
`else
  assign move_count = 8'd0;
`endif

endmodule

// File: tb/tb_player_move_requester.sv
// Randomized scoreboard bench for player_move_requester with a behavioural
// forbidden-move checker and map model.
module tb_player_move_requester;

`ifdef MOVE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] cmd_dir;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] chk_posx;
  logic [1:0] chk_posy;
  logic [2:0] chk_dir;
  logic       chk_valid;
  logic [2:0] chk_positionx;
  logic [1:0] chk_positiony;
  logic [2:0] pos_x;
  logic [1:0] pos_y;
  logic       move_done;
  logic       bump;
  logic [7:0] move_count;

  player_move_requester #(.START_X(3'd0), .START_Y(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_dir(cmd_dir), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .chk_posx(chk_posx), .chk_posy(chk_posy),
    .chk_dir(chk_dir), .chk_valid(chk_valid), .chk_positionx(chk_positionx),
    .chk_positiony(chk_positiony), .pos_x(pos_x), .pos_y(pos_y),
    .move_done(move_done), .bump(bump), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] forbid = '0;   // bit y*8+x set = checker refuses entry to that cell

  // External checker: target cell if on-map and allowed, else stay put.
  always_comb begin
    int tx, ty;
    tx = int'(chk_posx);
    ty = int'(chk_posy);
    case (chk_dir)
      3'd0: ty = ty - 1;
      3'd1: ty = ty + 1;
      3'd2: tx = tx + 1;
      3'd3: tx = tx - 1;
      default: ;
    endcase
    chk_positionx = chk_posx;
    chk_positiony = chk_posy;
    if (tx >= 0 && tx < 8 && ty >= 0 && ty < 4 && !forbid[ty*8 + tx]) begin
      chk_positionx = 3'(tx);
      chk_positiony = 2'(ty);
    end
  end

  typedef struct { int x; int y; bit bmp; int cnt; } exp_t;
  exp_t sb[$];

  int mx, my, mcnt;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: apply one command to the map model at the abstract level.
  task automatic model_step(input int dir, output exp_t e, output bit req, output int d);
    int nx, ny;
    d   = (dir > 4) ? 4 : dir;
    req = 1'b0;
    e.cnt = mcnt;
    e.bmp = 1'b0;
    nx = mx + ((d == 2) ? 1 : (d == 3) ? -1 : 0);
    ny = my + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
    if (d != 4) begin
      if (nx < 0 || nx > 7 || ny < 0 || ny > 3) e.bmp = 1'b1;
      else begin
        req = 1'b1;
        if (forbid[ny*8 + nx]) e.bmp = 1'b1;
        else begin mx = nx; my = ny; end
      end
      if (!e.bmp) mcnt = CNT_EN ? ((mcnt < 255) ? mcnt + 1 : 255) : 0;
    end
    e.x = mx;
    e.y = my;
  endtask

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!cmd_ready && t < 20) begin @(negedge clk); t++; end
    ok = cmd_ready;
    if (!ok) begin
      n_err++;
      $display("FAIL ready_timeout: cmd_ready stuck at 0, required 1");
    end
  endtask

  task automatic issue(input int dir, input bit hold);
    exp_t e; bit req, ok; int d, ox, oy;
    @(negedge clk);
    cmd_dir   = 3'(dir);
    cmd_valid = 1'b1;
    wait_ready(ok);
    if (!ok) begin cmd_valid = 1'b0; return; end
    ox = mx; oy = my;
    model_step(dir, e, req, d);
    sb.push_back(e);
    @(negedge clk);                       // REQ
    if (!hold) cmd_valid = 1'b0;
    check("chk_valid", int'(chk_valid), int'(req));
    check("chk_dir", int'(chk_dir), d);
    check("chk_posx", int'(chk_posx), ox);
    check("chk_posy", int'(chk_posy), oy);
    check("ready_req", int'(cmd_ready), 0);
    @(negedge clk);                       // RESP
    check("chk_valid_resp", int'(chk_valid), 0);
    check("chk_dir_resp", int'(chk_dir), 4);
    check("ready_resp", int'(cmd_ready), 0);
    @(negedge clk);                       // back in IDLE
    cmd_valid = 1'b0;
    check("ready_idle", int'(cmd_ready), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pos_x"}, int'(pos_x), 0);
    check({tag, "_pos_y"}, int'(pos_y), 0);
    check({tag, "_ready"}, int'(cmd_ready), 1);
    check({tag, "_chk_valid"}, int'(chk_valid), 0);
    check({tag, "_chk_dir"}, int'(chk_dir), 4);
    check({tag, "_done"}, int'(move_done), 0);
    check({tag, "_bump"}, int'(bump), 0);
    check({tag, "_count"}, int'(move_count), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mx = 0; my = 0; mcnt = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
  endtask

  // Monitor: every move_done must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (move_done) begin
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: move_done=1 with no command outstanding");
        end else begin
          e = sb.pop_front();
          check("pos_x", int'(pos_x), e.x);
          check("pos_y", int'(pos_y), e.y);
          check("bump", int'(bump), int'(e.bmp));
          check("move_count", int'(move_count), e.cnt);
        end
      end else if (bump) begin
        n_err++;
        $display("FAIL bump_without_done: bump=1, required 0");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 3'd0;
    mx = 0; my = 0; mcnt = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("init");
    rst_n = 1'b1;

    // Basic moves and a checker refusal from (2,0)
    issue(2, 0);
    issue(2, 0);
    forbid = 32'h0000_0008;
    issue(2, 0);
    forbid = '0;

    // Edge guards at (0,0) and (7,3)
    do_reset();
    issue(0, 0);
    issue(3, 0);
    for (int i = 0; i < 7; i++) issue(2, 0);
    for (int i = 0; i < 3; i++) issue(1, i == 1);
    issue(2, 0);
    issue(1, 0);

    // Undefined codes act as NONE; held cmd_valid consumed only once
    issue(6, 1);
    issue(5, 0);
    issue(3, 1);

    // Randomized traffic over random forbidden maps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) forbid = $urandom;
      issue($urandom_range(0, 7), $urandom_range(0, 3) == 0);
    end

    // Reset during REQ discards the command
    forbid = '0;
    @(negedge clk);
    cmd_dir   = (mx < 7) ? 3'd2 : 3'd3;
    cmd_valid = 1'b1;
    wait_ready(ok);
    @(negedge clk);
    check("abort_chk_valid", int'(chk_valid), 1);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    mx = 0; my = 0; mcnt = 0;
    #1;
    check_reset_vals("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1, 0);

    // Long run of successful moves to reach counter saturation
    for (int i = 0; i < 260; i++) issue((mx < 7) ? 2 : 3, 0);
    check("move_count_final", int'(move_count), mcnt);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
